axi_slave_packetizer: RTL

AXI4 slave-side front end of the MemorEDF scheduler. It accepts one transaction at a time on the AW/W or AR channels and packs it into the 678-bit scheduler packet: 1-bit type, 101-bit metadata, 4x16-bit strobes and 4x128-bit data. It presents the packet on a valid/ready handshake toward the EDF queues. The packet format is exactly the one the Serializer consumes. B and R responses are returned by the downstream pass-through path; this block never drives them.

---
 rtl/axi_slave_packetizer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_slave_packetizer.sv
// AXI4 slave front end: accepts one AW/W or AR transaction at a time and packs it
// into a 678-bit scheduler packet, offered on a valid/ready handshake.
module axi_slave_packetizer #(
    parameter int C_S_AXI_ID_WIDTH   = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_MAX_BEATS        = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWLOCK,
    input  logic [3:0]                        S_AXI_AWCACHE,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic [3:0]                        S_AXI_AWQOS,
    input  logic [3:0]                        S_AXI_AWREGION,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARLOCK,
    input  logic [3:0]                        S_AXI_ARCACHE,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic [3:0]                        S_AXI_ARQOS,
    input  logic [3:0]                        S_AXI_ARREGION,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic                              valid,
    input  logic                              ready,
    output logic [677:0]                      packet
);

    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam int META_W   = C_S_AXI_ADDR_WIDTH + C_S_AXI_ID_WIDTH + 29;
    localparam int META_FLD = 101;
    localparam int DATA_TOP = C_MAX_BEATS * C_S_AXI_DATA_WIDTH - 1;
    localparam int STRB_TOP = C_MAX_BEATS * (C_S_AXI_DATA_WIDTH + STRB_W) - 1;
    localparam int PKT_W    = 1 + META_FLD + STRB_TOP + 1;

    typedef enum logic [1:0] {IDLE, WDATA, EMIT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic [7:0]         len_q, len_d;
    logic               last_grant_q, last_grant_d;  // 1 = write was last served
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic               aw_ready, ar_ready, w_ready, emit;
    logic               grant_w, grant_r;
    logic [META_W-1:0]  meta_aw, meta_ar;

    assign meta_aw = {S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION};
    assign meta_ar = {S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                      S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION};

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        last_grant_d = last_grant_q;
        pkt_d        = pkt_q;
        aw_ready     = 1'b0;
        ar_ready     = 1'b0;
        w_ready      = 1'b0;
        emit         = 1'b0;
        grant_w      = 1'b0;
        grant_r      = 1'b0;
        case (state_q)
            IDLE: begin
                // Writes win a tie only when the previous grant went to a read
                grant_w  = S_AXI_AWVALID && (!S_AXI_ARVALID || !last_grant_q);
                grant_r  = S_AXI_ARVALID && !grant_w;
                aw_ready = grant_w;
                ar_ready = grant_r;
                if (grant_w) begin
                    pkt_d                         = '0;
                    pkt_d[PKT_W-1]                = 1'b1;
                    pkt_d[PKT_W-2 -: META_FLD]    = META_FLD'(meta_aw);
                    beat_cnt_d                    = '0;
                    len_d                         = S_AXI_AWLEN;
                    state_d                       = WDATA;
                end else if (grant_r) begin
                    pkt_d                         = '0;
                    pkt_d[PKT_W-2 -: META_FLD]    = META_FLD'(meta_ar);
                    state_d                       = EMIT;
                end
            end
            WDATA: begin
                w_ready = 1'b1;
                if (S_AXI_WVALID) begin
                    for (int k = 0; k < C_MAX_BEATS; k++) begin
                        if (beat_cnt_q == 8'(k)) begin
                            pkt_d[STRB_TOP - STRB_W*k -: STRB_W]                         = S_AXI_WSTRB;
                            pkt_d[DATA_TOP - C_S_AXI_DATA_WIDTH*k -: C_S_AXI_DATA_WIDTH] = S_AXI_WDATA;
                        end
                    end
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                    if (S_AXI_WLAST || (beat_cnt_q == len_q)) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                emit = 1'b1;
                if (ready) begin
                    last_grant_d = pkt_q[PKT_W-1];
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            last_grant_q <= 1'b0;
            pkt_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            last_grant_q <= last_grant_d;
            pkt_q        <= pkt_d;
        end
    end

    // The IDLE grant is combinational, so mask it while reset is held
    assign S_AXI_AWREADY = aw_ready & ~S_AXI_ARESET;
    assign S_AXI_ARREADY = ar_ready & ~S_AXI_ARESET;
    assign S_AXI_WREADY  = w_ready & ~S_AXI_ARESET;
    assign valid         = emit;
    assign packet        = pkt_q;

endmodule
